// File: rtl/period_meter_pkg.sv
// Shared definitions for period_meter and future sensor front-ends:
// FSM state encoding and the default synchronizer depth.
package period_meter_pkg;

  typedef enum logic {
    STATE_IDLE    = 1'b0,
    STATE_MEASURE = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_signal_synchronizer.sv
// Multi-flop synchronizer that brings an asynchronous sensor line into the clock domain.
// Every stage clears to 0 on the asynchronous active-low reset.
module signal_synchronizer
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous square wave in system clocks,
// with timeout and measuring flag. Define PERIOD_METER_DUTY_MEASURE_EN to add high_time_out.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 16,
  parameter int unsigned TIMEOUT_MAX  = 50000,
  parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    signal_in,
  output logic [COUNTER_SIZE-1:0] period_out,
  output logic                    period_valid,
  output logic                    timeout,
  output logic                    measuring
`ifdef PERIOD_METER_DUTY_MEASURE_EN
  ,
  output logic [COUNTER_SIZE-1:0] high_time_out
`endif
);

  localparam logic [COUNTER_SIZE-1:0] CNT_LAST = COUNTER_SIZE'(TIMEOUT_MAX - 1);

  logic                    sync_out;
  logic                    prev_q;
  logic                    rise;

  state_t                  state_q, state_d;
  logic [COUNTER_SIZE-1:0] counter_q, counter_d;
  logic [COUNTER_SIZE-1:0] counter_inc;
  logic [COUNTER_SIZE-1:0] period_q, period_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic                    measuring_q, measuring_d;

  signal_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .async_i(signal_in),
    .sync_o (sync_out)
  );

  assign rise        = sync_out & ~prev_q;
  assign counter_inc = counter_q + COUNTER_SIZE'(1);

  // An edge arriving on the last counted cycle wins over the timeout.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    measuring_d = (state_q == STATE_MEASURE);
    case (state_q)
      STATE_IDLE: begin
        counter_d = '0;
        if (rise) begin
          state_d = STATE_MEASURE;
        end
      end
      STATE_MEASURE: begin
        if (rise) begin
          period_d  = counter_inc;
          valid_d   = 1'b1;
          counter_d = '0;
        end else if (counter_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = STATE_IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter_inc;
        end
      end
      default: begin
        state_d   = STATE_IDLE;
        counter_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= 1'b0;
      state_q     <= STATE_IDLE;
      counter_q   <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      measuring_q <= 1'b0;
    end else begin
      prev_q      <= sync_out;
      state_q     <= state_d;
      counter_q   <= counter_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      measuring_q <= measuring_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign measuring    = measuring_q;

`ifdef PERIOD_METER_DUTY_MEASURE_EN
  logic                    fall;
  logic [COUNTER_SIZE-1:0] hold_q, hold_d;
  logic                    fall_seen_q, fall_seen_d;
  logic [COUNTER_SIZE-1:0] high_q, high_d;

  assign fall = ~sync_out & prev_q;

  // Without a fall inside the period the line was high throughout: report the full period.
  always_comb begin
    hold_d      = hold_q;
    fall_seen_d = fall_seen_q;
    high_d      = high_q;
    if (state_q == STATE_MEASURE) begin
      if (rise) begin
        high_d      = fall_seen_q ? hold_q : counter_inc;
        fall_seen_d = 1'b0;
      end else if (counter_q == CNT_LAST) begin
        fall_seen_d = 1'b0;
      end else if (fall) begin
        hold_d      = counter_inc;
        fall_seen_d = 1'b1;
      end
    end else begin
      fall_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      fall_seen_q <= 1'b0;
      high_q      <= '0;
    end else begin
      hold_q      <= hold_d;
      fall_seen_q <= fall_seen_d;
      high_q      <= high_d;
    end
  end

  assign high_time_out = high_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: event-level reference model compared every cycle,
// plus literal per-scenario expectations.
module tb_period_meter;

  localparam int TMAX = 100;
  localparam int S    = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        signal_in;
  logic [15:0] period_out;
  logic        period_valid;
  logic        timeout;
  logic        measuring;
`ifdef PERIOD_METER_DUTY_MEASURE_EN
  logic [15:0] high_time_out;
`endif

  period_meter #(
    .COUNTER_SIZE(16),
    .TIMEOUT_MAX (TMAX),
    .SYNC_STAGES (S)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .signal_in   (signal_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .timeout     (timeout),
    .measuring   (measuring)
`ifdef PERIOD_METER_DUTY_MEASURE_EN
    ,
    .high_time_out(high_time_out)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_v    = 0;
  int cnt_t    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks edge times of the sampled input, seen S clocks after sampling.
  bit          hist[$];
  int          e        = 0;
  bit          armed    = 0;
  bit          fseen    = 0;
  int          last_r   = 0;
  int          fall_e   = 0;
  logic [15:0] exp_period = '0;
  logic [15:0] exp_high   = '0;
  logic        exp_valid  = 1'b0;
  logic        exp_tmo    = 1'b0;
  logic        exp_meas   = 1'b0;

  function automatic bit smp(input int idx);
    if (idx < 1 || idx > hist.size()) return 1'b0;
    return hist[idx-1];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit cur, prv, r, f;
    if (!reset_n) begin
      hist.delete();
      e = 0; armed = 0; fseen = 0; last_r = 0; fall_e = 0;
      exp_period = '0; exp_high = '0;
      exp_valid = 1'b0; exp_tmo = 1'b0; exp_meas = 1'b0;
    end else begin
      e++;
      hist.push_back(signal_in);
      cur = smp(e - S);
      prv = smp(e - S - 1);
      r = cur & ~prv;
      f = ~cur & prv;
      exp_meas  = armed;
      exp_valid = 1'b0;
      exp_tmo   = 1'b0;
      if (r) begin
        if (armed) begin
          exp_valid  = 1'b1;
          exp_period = 16'(e - last_r);
          exp_high   = fseen ? 16'(fall_e - last_r) : 16'(e - last_r);
        end
        armed  = 1;
        last_r = e;
        fseen  = 0;
      end else if (armed && (e - last_r) == TMAX) begin
        exp_tmo = 1'b1;
        armed   = 0;
        fseen   = 0;
      end else if (f && armed) begin
        fseen  = 1;
        fall_e = e;
      end
    end
  end

  always @(negedge clock) begin
    chk("period_out", period_out, exp_period);
    chk("period_valid", period_valid, exp_valid);
    chk("timeout", timeout, exp_tmo);
    chk("measuring", measuring, exp_meas);
`ifdef PERIOD_METER_DUTY_MEASURE_EN
    chk("high_time_out", high_time_out, exp_high);
`endif
    if (period_valid) cnt_v++;
    if (timeout) cnt_t++;
  end

  task automatic gen(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      signal_in = 1'b1;
      repeat (hi) @(negedge clock);
      signal_in = 1'b0;
      repeat (lo) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    signal_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic scen_check(input string tag, input int v, input int t, input int p, input int m);
    chk({tag, ".valid_count"}, cnt_v, v);
    chk({tag, ".timeout_count"}, cnt_t, t);
    chk({tag, ".period_lit"}, period_out, p);
    chk({tag, ".measuring_lit"}, measuring, m);
    cnt_v = 0;
    cnt_t = 0;
  endtask

  initial begin
    reset_n   = 1'b1;
    signal_in = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    scen_check("reset", 0, 0, 0, 0);

    // Period 50: first rise arms, then 5 periods
    gen(25, 25, 6);
    idle(130);
    scen_check("p50", 5, 1, 50, 0);

    // Period 100 accepted; gap 101 times out first; then line goes quiet
    gen(50, 50, 4);
    gen(50, 51, 1);
    gen(50, 51, 1);
    idle(150);
    scen_check("p100_101", 4, 2, 100, 0);

    // Re-arm after timeout with period 60
    gen(30, 30, 3);
    idle(130);
    scen_check("p60", 2, 1, 60, 0);

    // Asynchronous reset in the middle of a high phase
    gen(25, 25, 3);
    signal_in = 1'b1;
    repeat (10) @(negedge clock);
    scen_check("pre_reset", 3, 0, 50, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst.period_out", period_out, 0);
    chk("async_rst.period_valid", period_valid, 0);
    chk("async_rst.timeout", timeout, 0);
    chk("async_rst.measuring", measuring, 0);
    signal_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cnt_v = 0;
    cnt_t = 0;
    gen(25, 25, 3);
    idle(130);
    scen_check("post_reset", 2, 1, 50, 0);

    // Fastest input: toggles every clock
    gen(1, 1, 20);
    idle(130);
    scen_check("p2", 19, 1, 2, 0);

`ifdef PERIOD_METER_DUTY_MEASURE_EN
    gen(20, 30, 4);
    idle(130);
    chk("duty.high_lit", high_time_out, 20);
    scen_check("duty", 3, 1, 50, 0);
`endif

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
